// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: state codes and the "no best time yet" value.
package reaction_timer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    GO     = 3'd2,
    RESULT = 3'd3,
    FAULT  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // All-ones pattern of the given width, used as the "no valid time" marker.
  function automatic logic [31:0] best_none(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/key_press_edge.sv
// Falling-edge detector for an active-low, already-synchronised key.
// A held key produces exactly one press pulse.
module key_press_edge (
  input  logic i_clk,
  input  logic i_clear_n,
  input  logic i_key_n,
  output logic o_press
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_clear_n) r_prev <= 1'b1;
    else            r_prev <= i_key_n;
  end

  assign o_press = r_prev & ~i_key_n;

endmodule

// File: rtl/reaction_timer_fsm.sv
// Multi-round reaction timer: random delay, timed stop press, false-start and
// timeout detection, and best-time tracking across ROUNDS rounds.
module reaction_timer_fsm
  import reaction_timer_pkg::*;
#(
  parameter int TIME_W     = 14,
  parameter int DELAY_W    = 12,
  parameter int ROUNDS     = 5,
  parameter int TIMEOUT_MS = 9999
) (
  input  logic                       i_clk,
  input  logic                       i_clear_n,
  input  logic                       i_tick_ms,
  input  logic                       i_start_n,
  input  logic                       i_stop_n,
  input  logic [DELAY_W-1:0]         i_delay_seed,
  output logic [STATE_W-1:0]         o_state,
  output logic                       o_led_go,
  output logic [TIME_W-1:0]          o_elapsed,
  output logic [TIME_W-1:0]          o_best,
  output logic [$clog2(ROUNDS):0]    o_round_idx,
  output logic                       o_false_start,
  output logic                       o_timeout,
  output logic                       o_done
);

  localparam int RIDX_W = $clog2(ROUNDS) + 1;
  localparam logic [TIME_W-1:0] BEST_NONE  = TIME_W'(best_none(TIME_W));
  localparam logic [TIME_W-1:0] TIMEOUT_V  = TIME_W'(TIMEOUT_MS);
  localparam logic [TIME_W-1:0] TIMEOUT_M1 = TIME_W'(TIMEOUT_MS - 1);
  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);

  state_t              r_state, w_state;
  logic [DELAY_W-1:0]  r_delay_cnt, w_delay_cnt;
  logic [TIME_W-1:0]   r_elapsed, w_elapsed;
  logic [TIME_W-1:0]   r_best, w_best;
  logic [RIDX_W-1:0]   r_round_idx, w_round_idx;
  logic                r_false_start, w_false_start;
  logic                r_timeout, w_timeout;
  logic                w_arm;
  logic                w_start;
  logic                w_stop;

  key_press_edge u_start_edge (
    .i_clk     (i_clk),
    .i_clear_n (i_clear_n),
    .i_key_n   (i_start_n),
    .o_press   (w_start)
  );

  key_press_edge u_stop_edge (
    .i_clk     (i_clk),
    .i_clear_n (i_clear_n),
    .i_key_n   (i_stop_n),
    .o_press   (w_stop)
  );

  always_ff @(posedge i_clk) begin
    if (!i_clear_n) r_state <= IDLE;
    else            r_state <= w_state;
  end

  // ARM and GO only listen to stop; every other state only listens to start.
  always_comb begin
    w_state       = r_state;
    w_delay_cnt   = r_delay_cnt;
    w_elapsed     = r_elapsed;
    w_best        = r_best;
    w_round_idx   = r_round_idx;
    w_false_start = r_false_start;
    w_timeout     = r_timeout;
    w_arm         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_arm       = 1'b1;
          w_best      = BEST_NONE;
          w_round_idx = '0;
          w_state     = ARM;
        end
      end
      ARM: begin
        if (w_stop) begin
          w_state       = FAULT;
          w_false_start = 1'b1;
          w_delay_cnt   = '0;
        end else if (i_tick_ms) begin
          if (r_delay_cnt <= DELAY_W'(1)) begin
            w_state     = GO;
            w_elapsed   = '0;
            w_delay_cnt = '0;
          end else begin
            w_delay_cnt = r_delay_cnt - 1'b1;
          end
        end
      end
      GO: begin
        if (w_stop) begin
          w_state = RESULT;
          if (r_elapsed < r_best) w_best = r_elapsed;
        end else if (i_tick_ms) begin
          if (r_elapsed >= TIMEOUT_M1) begin
            w_elapsed = TIMEOUT_V;
            w_timeout = 1'b1;
            w_state   = RESULT;
          end else begin
            w_elapsed = r_elapsed + 1'b1;
          end
        end
      end
      RESULT: begin
        if (w_start) begin
          if (r_round_idx == LAST_ROUND) begin
            w_state = DONE;
          end else begin
            w_round_idx = r_round_idx + 1'b1;
            w_arm       = 1'b1;
            w_state     = ARM;
          end
        end
      end
      FAULT: begin
        if (w_start) begin
          w_arm   = 1'b1;
          w_state = ARM;
        end
      end
      DONE: begin
        if (w_start) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase

    if (w_arm) begin
      w_delay_cnt   = (i_delay_seed == '0) ? DELAY_W'(1) : i_delay_seed;
      w_false_start = 1'b0;
      w_timeout     = 1'b0;
      w_elapsed     = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clear_n) begin
      r_delay_cnt   <= '0;
      r_elapsed     <= '0;
      r_best        <= BEST_NONE;
      r_round_idx   <= '0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_delay_cnt   <= w_delay_cnt;
      r_elapsed     <= w_elapsed;
      r_best        <= w_best;
      r_round_idx   <= w_round_idx;
      r_false_start <= w_false_start;
      r_timeout     <= w_timeout;
    end
  end

  assign o_state       = r_state;
  assign o_led_go      = (r_state == GO);
  assign o_done        = (r_state == DONE);
  assign o_elapsed     = r_elapsed;
  assign o_best        = r_best;
  assign o_round_idx   = r_round_idx;
  assign o_false_start = r_false_start;
  assign o_timeout     = r_timeout;

endmodule
